// File: rtl/proc_pkg.sv
// Shared pipeline constants and the multiply/divide sequencer state type.
package proc_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned RIDX_W = 5;

   localparam logic [4:0] OPC_ALU   = 5'd0;
   localparam logic [4:0] ALUOP_MUL = 5'd6;
   localparam logic [4:0] ALUOP_DIV = 5'd7;

   localparam int unsigned DEF_MAX_CYCLES   = 40;
   localparam int unsigned DEF_RSTATUS_REG  = 30;
   localparam int unsigned DEF_MUL_EXC_CODE = 4;
   localparam int unsigned DEF_DIV_EXC_CODE = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } md_state_t;

endpackage

// File: rtl/md_decode.sv
// Recognises MUL/DIV in an instruction word; shared with the hazard unit.
module md_decode
   import proc_pkg::*;
(
   input  logic [31:0] ir_i,
   output logic        is_md_o,
   output logic        is_div_o,
   output logic [4:0]  rd_o
);

   logic is_alu;
   logic unused_ir;

   assign is_alu    = (ir_i[31:27] == OPC_ALU);
   assign is_md_o   = is_alu && ((ir_i[6:2] == ALUOP_MUL) || (ir_i[6:2] == ALUOP_DIV));
   assign is_div_o  = is_alu && (ir_i[6:2] == ALUOP_DIV);
   assign rd_o      = ir_i[26:22];
   assign unused_ir = ^{ir_i[21:7], ir_i[1:0]};

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequences the multicycle multiply/divide unit and returns its result to X/M.
module multdiv_ctrl
   import proc_pkg::*;
#(
   parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
   parameter int unsigned RSTATUS_REG  = DEF_RSTATUS_REG,
   parameter int unsigned MUL_EXC_CODE = DEF_MUL_EXC_CODE,
   parameter int unsigned DIV_EXC_CODE = DEF_DIV_EXC_CODE
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] DXIR,
   input  logic [31:0] dx_a,
   input  logic [31:0] dx_b,
   input  logic        kill,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic [31:0] data_result,
   input  logic        data_exception,
   input  logic        data_resultRDY,
   output logic        md_stall,
   output logic        md_valid,
   output logic [4:0]  md_rd,
   output logic [31:0] md_data
);

   localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

   md_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [RIDX_W-1:0] rd_q, rd_d;
   logic              div_q, div_d;
   logic [RIDX_W-1:0] res_rd_q, res_rd_d;
   logic [XLEN-1:0]   res_data_q, res_data_d;

   logic              dec_md, dec_div;
   logic [RIDX_W-1:0] dec_rd;
   logic              issue;
   logic              fin, fin_exc;

   md_decode u_decode (
      .ir_i     (DXIR),
      .is_md_o  (dec_md),
      .is_div_o (dec_div),
      .rd_o     (dec_rd)
   );

   assign issue = dec_md && !kill;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: kill aborts an in-flight op but never one already in DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (issue) state_d = START;
         START:   state_d = kill ? IDLE : BUSY;
         BUSY: begin
            if (kill)                                       state_d = IDLE;
            else if (data_resultRDY || (cnt_q == CNT_LAST)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand latch, watchdog counter and write-back formation.
   always_comb begin
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      rd_d       = rd_q;
      div_d      = div_q;
      res_rd_d   = res_rd_q;
      res_data_d = res_data_q;
      fin        = 1'b0;
      fin_exc    = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               a_d   = dx_a;
               b_d   = dx_b;
               rd_d  = dec_rd;
               div_d = dec_div;
            end
         end
         START: cnt_d = '0;
         BUSY: begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
            if (!kill) begin
               if (data_resultRDY) begin
                  fin     = 1'b1;
                  fin_exc = data_exception;
               end else if (cnt_q == CNT_LAST) begin
                  fin     = 1'b1;
                  fin_exc = 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (fin) begin
         if (fin_exc) begin
            res_rd_d   = RIDX_W'(RSTATUS_REG);
            res_data_d = div_q ? XLEN'(DIV_EXC_CODE) : XLEN'(MUL_EXC_CODE);
         end else begin
            res_rd_d   = rd_q;
            res_data_d = data_result;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rd_q       <= '0;
         div_q      <= 1'b0;
         res_rd_q   <= '0;
         res_data_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rd_q       <= rd_d;
         div_q      <= div_d;
         res_rd_q   <= res_rd_d;
         res_data_q <= res_data_d;
      end
   end

   // Strobes; the IDLE stall is combinational so the issuing cycle freezes too.
   always_comb begin
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      md_stall  = 1'b0;
      md_valid  = 1'b0;
      case (state_q)
         IDLE:  md_stall = reset && issue;
         START: begin
            ctrl_MULT = !div_q;
            ctrl_DIV  = div_q;
            md_stall  = 1'b1;
         end
         BUSY:  md_stall = 1'b1;
         DONE:  md_valid = 1'b1;
         default: ;
      endcase
   end

   assign md_a    = a_q;
   assign md_b    = b_q;
   assign md_rd   = res_rd_q;
   assign md_data = res_data_q;

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequences the multicycle multiply/divide unit for the 5-stage pipeline.
- Detects MUL/DIV in the D/X latch, holds the front of the pipeline while the unit runs, and launches the operation with a one-cycle start pulse.
- Returns the result, or an exception write to $rstatus, to the X/M latch as a single-cycle valid.
- Sits beside the ALU decode in X; the hazard unit ORs md_stall into its freeze logic.

Parameters:
MAX_CYCLES, 40, BUSY cycles allowed before the operation is forced to finish with an exception
RSTATUS_REG, 30, register index written on exception
MUL_EXC_CODE, 4, $rstatus value for multiply overflow
DIV_EXC_CODE, 5, $rstatus value for divide-by-zero or timeout on DIV

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
DXIR  in  32  instruction in the D/X latch
dx_a  in  32  operand A from the D/X latch
dx_b  in  32  operand B from the D/X latch
kill  in  1  squash the D/X instruction (taken branch or jump)
ctrl_MULT  out  1  one-cycle start pulse to the unit, multiply
ctrl_DIV  out  1  one-cycle start pulse to the unit, divide
md_a  out  32  latched operand A to the unit
md_b  out  32  latched operand B to the unit
data_result  in  32  unit result
data_exception  in  1  unit exception flag, valid with data_resultRDY
data_resultRDY  in  1  unit done strobe
md_stall  out  1  freeze PC/FD/DX and insert a bubble into X/M
md_valid  out  1  one-cycle X/M write strobe
md_rd  out  5  destination register
md_data  out  32  write-back data

Behaviour:
- Decode: is_md = (DXIR[31:27]==0) && (DXIR[6:2]==6 or 7). Op 6 is MUL, op 7 is DIV. rd = DXIR[26:22].
- States: IDLE, START, BUSY, DONE. Encoding is 2 bits.
- Reset (asynchronous, reset==0):
  - State goes to IDLE; the cycle counter clears.
  - md_a, md_b, md_rd, md_data, and the latched op clear to 0.
  - All 1-bit outputs are 0.
- IDLE:
  - If is_md && !kill: latch dx_a, dx_b, rd, and op; next state START.
  - md_stall = is_md && !kill, combinational in the same cycle.
  - Otherwise remain in IDLE.
- START:
  - Assert exactly one of ctrl_MULT or ctrl_DIV for this cycle only.
  - Clear the counter; next state BUSY; md_stall=1.
- BUSY:
  - md_stall=1; the counter increments each cycle.
  - If data_resultRDY: capture data_result and data_exception; next state DONE.
  - Else if counter == MAX_CYCLES-1: force the exception flag; next state DONE.
- DONE:
  - md_valid=1 and md_stall=0, so the pipeline advances at the end of this cycle. Next state IDLE.
  - No exception: md_rd = latched rd, md_data = result.
  - Exception: md_rd = RSTATUS_REG, md_data = MUL_EXC_CODE or DIV_EXC_CODE according to the latched op.
- md_rd and md_data are registered and hold their value outside DONE. md_valid is the only strobe.
- Latency: MUL/DIV in DX at cycle t; start pulse at t+1; if RDY arrives at cycle k, md_valid is at k+1. The stall spans t..k.
- kill asserted in START or BUSY:
  - Abort to IDLE next cycle; no md_valid.
  - A RDY pulse arriving later is ignored.
  - kill wins over a simultaneous RDY.
- kill in DONE is ignored: the instruction has already completed.
- data_resultRDY outside BUSY is ignored.
- Back-to-back MUL/DIV: the DONE→IDLE cycle sees the new DXIR and starts again. There is no lost cycle beyond IDLE.
- The counter saturates and never wraps. Its width is clog2(MAX_CYCLES)+1.
- rd==0 is still signalled with md_valid; the register file discards the write.

Decomposition:
- Package proc_pkg holds:
  - OPC_ALU=5'd0, ALUOP_MUL=5'd6, ALUOP_DIV=5'd7
  - state typedef md_state_t {IDLE, START, BUSY, DONE}
  - RSTATUS_REG, MUL_EXC_CODE, DIV_EXC_CODE defaults
- One natural sub-module: md_decode (combinational; DXIR → is_md, is_div, rd). It is reusable by the hazard unit.

Test Plan:
- Reset held low mid-BUSY → all outputs 0 immediately, state IDLE; release → no start pulse without a new MUL.
- MUL (op 6, rd=5) with a=7, b=6; RDY 17 cycles after start, result 42 → md_stall high from issue through the RDY cycle; md_valid 1 cycle later with md_rd=5, md_data=42.
- DIV with b=0; unit returns exception → md_valid with md_rd=30, md_data=5; ctrl_DIV pulsed exactly once.
- MUL issued with kill=1 in the same cycle → no stall, no ctrl_MULT; kill on the 5th BUSY cycle with RDY simultaneous → IDLE, md_valid never asserted.
- Unit never raises RDY on a MUL → md_valid exactly MAX_CYCLES (40) BUSY cycles later with md_rd=30, md_data=4.
- Two consecutive MULs, RDY after 3 cycles each → two start pulses and two md_valid pulses, with correct rd/data ordering and the second start directly after DONE.
